// File: rtl/onchip_mem_pkg.sv
// Shared types and default widths for the two-master on-chip RAM arbiter.
package onchip_mem_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] address;
    logic [BE_W_DEF-1:0]   byteenable;
    logic                  read;
    logic                  write;
    logic [DATA_W_DEF-1:0] writedata;
    logic                  lock;
  } port_req_t;

endpackage

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-input round-robin / fixed-priority grant with a per-port lock that
// pins the grant to one master across an atomic sequence.
module rr_arb2
  import onchip_mem_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  lock_state_e state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        held0, held1;

  always_comb begin
    // A lock only holds while its owner keeps lock high; dropping it
    // reopens arbitration in the same cycle.
    held0 = (state_q == LOCKED0) && lock[0];
    held1 = (state_q == LOCKED1) && lock[1];

    gnt = 2'b00;
    if (held0) begin
      gnt = {1'b0, req[0]};
    end else if (held1) begin
      gnt = {req[1], 1'b0};
    end else if (req == 2'b11) begin
      gnt = ((FIXED_PRIO != 0) || last_grant_q) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    if (!reset_n) gnt = 2'b00;

    last_grant_d = last_grant_q;
    if (gnt[1])      last_grant_d = 1'b1;
    else if (gnt[0]) last_grant_d = 1'b0;

    state_d = state_q;
    if (!held0 && !held1) begin
      state_d = UNLOCKED;
      if (gnt[0] && lock[0])      state_d = LOCKED0;
      else if (gnt[1] && lock[1]) state_d = LOCKED1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= UNLOCKED;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port synchronous RAM between two Avalon-MM masters:
// one access per cycle, reads returned one cycle later with readdatavalid.
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BE_W       = DATA_W / 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] p0_address,
  input  logic [BE_W-1:0]   p0_byteenable,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [DATA_W-1:0] p0_writedata,
  input  logic              p0_lock,
  output logic              p0_waitrequest,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_readdatavalid,

  input  logic [ADDR_W-1:0] p1_address,
  input  logic [BE_W-1:0]   p1_byteenable,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [DATA_W-1:0] p1_writedata,
  input  logic              p1_lock,
  output logic              p1_waitrequest,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic [1:0] req, lock, gnt;
  logic       acc_read;
  logic       rd_pending_q, rd_pending_d;
  logic       rd_owner_q, rd_owner_d;

  assign req  = {p1_read | p1_write, p0_read | p0_write};
  assign lock = {p1_lock, p0_lock};

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .lock    (lock),
    .gnt     (gnt)
  );

  always_comb begin
    // Port 0 drives the RAM bus whenever port 1 is not granted.
    ram_address    = gnt[1] ? p1_address    : p0_address;
    ram_byteenable = gnt[1] ? p1_byteenable : p0_byteenable;
    ram_writedata  = gnt[1] ? p1_writedata  : p0_writedata;
    ram_chipselect = |gnt;
    ram_write      = (gnt[0] & p0_write) | (gnt[1] & p1_write);
    // Read together with write is treated as a write.
    acc_read       = (gnt[0] & p0_read & ~p0_write) | (gnt[1] & p1_read & ~p1_write);

    rd_pending_d   = acc_read;
    rd_owner_d     = acc_read ? gnt[1] : rd_owner_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign ram_clken        = 1'b1;
  assign p0_waitrequest   = ~gnt[0];
  assign p1_waitrequest   = ~gnt[1];
  assign p0_readdata      = ram_readdata;
  assign p1_readdata      = ram_readdata;
  assign p0_readdatavalid = rd_pending_q & ~rd_owner_q;
  assign p1_readdatavalid = rd_pending_q & rd_owner_q;

  a_p0_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(p0_read && p0_write))
    else $error("port 0 asserted read and write together");
  a_p1_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(p1_read && p1_write))
    else $error("port 1 asserted read and write together");

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: behavioural RAM on the ram_* pins, directed
// scenarios plus random two-master traffic against a shadow-memory model.
module tb_onchip_mem_arbiter;
  import onchip_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [8:0]  p0_address, p1_address;
  logic [3:0]  p0_byteenable, p1_byteenable;
  logic        p0_read, p0_write, p0_lock, p1_read, p1_write, p1_lock;
  logic [31:0] p0_writedata, p1_writedata;
  logic        p0_waitrequest, p1_waitrequest, p0_readdatavalid, p1_readdatavalid;
  logic [31:0] p0_readdata, p1_readdata;
  logic [8:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read),
    .p0_write(p0_write), .p0_writedata(p0_writedata), .p0_lock(p0_lock),
    .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
    .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read),
    .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_lock(p1_lock),
    .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  // Synchronous single-port RAM, 1-cycle read latency, byte-enabled writes.
  logic [31:0] ram_mem [0:511];
  always @(posedge clk) begin
    if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= ram_mem[ram_address];
      end
    end
  end

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = nw[8*b +: 8];
  endfunction

  task automatic idle();
    p0_read = 0; p0_write = 0; p0_lock = 0; p1_read = 0; p1_write = 0; p1_lock = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    p0_address = '0; p0_byteenable = '0; p0_writedata = '0;
    p1_address = '0; p1_byteenable = '0; p1_writedata = '0;
    reset_n = 1'b0;
    p0_read = 1'b1;
    repeat (3) next();
    @(negedge clk);
    checks++; if (p0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_p0_wait got %b want 1", p0_waitrequest); end
    checks++; if (p1_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_p1_wait got %b want 1", p1_waitrequest); end
    checks++; if (ram_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got %b want 0", ram_chipselect); end
    checks++; if ({p0_readdatavalid, p1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL rst_valid got %b want 00", {p0_readdatavalid, p1_readdatavalid}); end
    next();
    idle();
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({p0_readdatavalid, p1_readdatavalid, ram_chipselect, ram_write, ram_clken} !== 5'b00001) begin
        errors++;
        $display("FAIL post_rst_idle cycle %0d got v0=%b v1=%b cs=%b wr=%b clken=%b want 0 0 0 0 1",
                 c, p0_readdatavalid, p1_readdatavalid, ram_chipselect, ram_write, ram_clken);
      end
      next();
    end
  endtask

  task automatic test_write_read();
    p0_address = 9'h005; p0_byteenable = 4'hF; p0_writedata = 32'hDEADBEEF; p0_write = 1;
    @(negedge clk);
    checks++; if (p0_waitrequest !== 1'b0) begin errors++; $display("FAIL wr_wait got %b want 0", p0_waitrequest); end
    checks++; if ({ram_chipselect, ram_write, ram_address} !== {2'b11, 9'h005}) begin errors++; $display("FAIL wr_ram cs=%b wr=%b addr=%h want 1 1 005", ram_chipselect, ram_write, ram_address); end
    next();
    p0_write = 0; p0_read = 1;
    @(negedge clk);
    checks++; if (p0_waitrequest !== 1'b0) begin errors++; $display("FAIL rd_wait got %b want 0", p0_waitrequest); end
    checks++; if ({ram_chipselect, ram_write} !== 2'b10) begin errors++; $display("FAIL rd_ram cs=%b wr=%b want 1 0", ram_chipselect, ram_write); end
    next();
    idle();
    @(negedge clk);
    checks++; if (p0_readdatavalid !== 1'b1) begin errors++; $display("FAIL rd_valid got %b want 1", p0_readdatavalid); end
    checks++; if (p0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", p0_readdata); end
    checks++; if (p1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_p1_valid got %b want 0", p1_readdatavalid); end
    next();
    @(negedge clk);
    checks++; if (p0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_valid_once got %b want 0", p0_readdatavalid); end
    next();
  endtask

  task automatic test_contention();
    int prev, exp_w, last_acc, nv0, nv1, w0, w1;
    // Preload through port 1 so port 0 is next in line.
    for (int a = 0; a < 2; a++) begin
      p1_address = 9'(9'h010 + a); p1_byteenable = 4'hF; p1_writedata = 32'(32'h10 + a); p1_write = 1;
      @(negedge clk);
      checks++; if (p1_waitrequest !== 1'b0) begin errors++; $display("FAIL preload_wait got %b want 0", p1_waitrequest); end
      next();
    end
    idle();
    next();
    prev = 1; last_acc = -1; nv0 = 0; nv1 = 0; w0 = 0; w1 = 0;
    p0_address = 9'h010; p0_read = 1; p1_address = 9'h011; p1_read = 1;
    for (int c = 0; c < 9; c++) begin
      if (c == 8) idle();
      @(negedge clk);
      checks++;
      if (p0_readdatavalid !== (last_acc == 0) || p1_readdatavalid !== (last_acc == 1)) begin
        errors++; $display("FAIL cont_valid cycle %0d got %b%b want owner %0d", c, p0_readdatavalid, p1_readdatavalid, last_acc);
      end else if (last_acc >= 0) begin
        checks++;
        if (p0_readdata !== 32'(32'h10 + last_acc)) begin errors++; $display("FAIL cont_data cycle %0d got %h want %h", c, p0_readdata, 32'h10 + last_acc); end
        if (last_acc == 0) nv0++; else nv1++;
      end
      if (c < 8) begin
        exp_w = 1 - prev;
        checks++;
        if (p0_waitrequest !== (exp_w != 0) || p1_waitrequest !== (exp_w != 1)) begin
          errors++; $display("FAIL cont_grant cycle %0d got wait %b%b want winner p%0d", c, p1_waitrequest, p0_waitrequest, exp_w);
        end
        if (p0_waitrequest) w0++; else w0 = 0;
        if (p1_waitrequest) w1++; else w1 = 0;
        checks++; if (w0 > 1 || w1 > 1) begin errors++; $display("FAIL cont_maxwait got %0d/%0d want <=1", w0, w1); end
        prev = exp_w; last_acc = exp_w;
      end else begin
        last_acc = -1;
      end
      next();
    end
    checks++; if (nv0 != 4 || nv1 != 4) begin errors++; $display("FAIL cont_count got %0d/%0d want 4/4", nv0, nv1); end
  endtask

  task automatic test_lock();
    int p0_waits = 0;
    // Port 0 writes 0x5 so that port 1 wins the upcoming conflict.
    p0_address = 9'h020; p0_byteenable = 4'hF; p0_writedata = 32'h5; p0_write = 1;
    next();
    idle();
    p0_address = 9'h020; p0_read = 1;
    p1_address = 9'h020; p1_read = 1; p1_lock = 1;
    @(negedge clk);
    if (p0_waitrequest) p0_waits++;
    checks++; if ({p1_waitrequest, p0_waitrequest} !== 2'b01) begin errors++; $display("FAIL lock_a got w1w0=%b%b want 01", p1_waitrequest, p0_waitrequest); end
    next();
    p1_read = 0; p1_write = 1; p1_writedata = 32'h6; p1_byteenable = 4'h1;
    @(negedge clk);
    if (p0_waitrequest) p0_waits++;
    checks++; if ({p1_waitrequest, p0_waitrequest} !== 2'b01) begin errors++; $display("FAIL lock_b got w1w0=%b%b want 01", p1_waitrequest, p0_waitrequest); end
    checks++; if (p1_readdatavalid !== 1'b1 || p1_readdata !== 32'h5) begin errors++; $display("FAIL lock_rd got v=%b d=%h want 1 00000005", p1_readdatavalid, p1_readdata); end
    next();
    p1_write = 0; p1_lock = 0;
    @(negedge clk);
    if (p0_waitrequest) p0_waits++;
    checks++; if (p0_waitrequest !== 1'b0) begin errors++; $display("FAIL lock_release got %b want 0", p0_waitrequest); end
    checks++; if (p0_waits != 2) begin errors++; $display("FAIL lock_waits got %0d want 2", p0_waits); end
    next();
    idle();
    @(negedge clk);
    checks++; if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'h6) begin errors++; $display("FAIL lock_final got v=%b d=%h want 1 00000006", p0_readdatavalid, p0_readdata); end
    next();
  endtask

  task automatic test_byte_lane();
    p1_address = 9'h030; p1_byteenable = 4'hF; p1_writedata = 32'h11223344; p1_write = 1;
    next();
    p1_byteenable = 4'h4; p1_writedata = 32'h00AA0000;
    @(negedge clk);
    checks++; if (p1_waitrequest !== 1'b0 || ram_byteenable !== 4'h4) begin errors++; $display("FAIL be_wr got wait=%b be=%h want 0 4", p1_waitrequest, ram_byteenable); end
    next();
    p1_write = 0; p1_read = 1;
    next();
    idle();
    @(negedge clk);
    checks++; if (p1_readdatavalid !== 1'b1 || p1_readdata !== 32'h11AA3344) begin errors++; $display("FAIL be_rd got v=%b d=%h want 1 11aa3344", p1_readdatavalid, p1_readdata); end
    next();
  endtask

  task automatic test_random();
    port_req_t   m [2];
    logic        act [2];
    logic [31:0] shadow [8];
    logic [31:0] pend_data;
    int          prev, win, pend_port, idx;
    int          waits [2];
    for (int a = 0; a < 8; a++) begin
      shadow[a] = $urandom;
      p0_address = 9'(9'h040 + a); p0_byteenable = 4'hF; p0_writedata = shadow[a]; p0_write = 1;
      @(negedge clk);
      checks++; if (p0_waitrequest !== 1'b0) begin errors++; $display("FAIL rnd_preload got %b want 0", p0_waitrequest); end
      next();
    end
    idle();
    prev = 0; pend_port = -1; pend_data = '0;
    for (int p = 0; p < 2; p++) begin act[p] = 0; waits[p] = 0; m[p] = '0; end
    for (int c = 0; c < 301; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (c < 300 && !act[p] && $urandom_range(0, 3) != 0) begin
          act[p] = 1;
          m[p] = '0;
          m[p].address = 9'(9'h040 + $urandom_range(0, 7));
          m[p].write = 1'($urandom_range(0, 1));
          m[p].read = ~m[p].write;
          m[p].byteenable = 4'($urandom);
          m[p].writedata = $urandom;
        end
      end
      p0_address = m[0].address; p0_byteenable = m[0].byteenable; p0_writedata = m[0].writedata;
      p0_read = act[0] & m[0].read; p0_write = act[0] & m[0].write;
      p1_address = m[1].address; p1_byteenable = m[1].byteenable; p1_writedata = m[1].writedata;
      p1_read = act[1] & m[1].read; p1_write = act[1] & m[1].write;
      @(negedge clk);
      if (act[0] && act[1]) win = 1 - prev;
      else if (act[0])      win = 0;
      else if (act[1])      win = 1;
      else                  win = -1;
      checks++; if (ram_chipselect !== (win >= 0)) begin errors++; $display("FAIL rnd_cs cycle %0d got %b want %b", c, ram_chipselect, win >= 0); end
      if (act[0]) begin checks++; if (p0_waitrequest !== (win != 0)) begin errors++; $display("FAIL rnd_p0_wait cycle %0d got %b want %b", c, p0_waitrequest, win != 0); end end
      if (act[1]) begin checks++; if (p1_waitrequest !== (win != 1)) begin errors++; $display("FAIL rnd_p1_wait cycle %0d got %b want %b", c, p1_waitrequest, win != 1); end end
      checks++;
      if (p0_readdatavalid !== (pend_port == 0) || p1_readdatavalid !== (pend_port == 1)) begin
        errors++; $display("FAIL rnd_valid cycle %0d got %b%b want owner %0d", c, p1_readdatavalid, p0_readdatavalid, pend_port);
      end else if (pend_port >= 0) begin
        checks++;
        if ((pend_port == 0 ? p0_readdata : p1_readdata) !== pend_data) begin
          errors++; $display("FAIL rnd_data cycle %0d got %h want %h", c, pend_port == 0 ? p0_readdata : p1_readdata, pend_data);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (act[p] && win != p) begin
          waits[p]++;
          checks++; if (waits[p] > 1) begin errors++; $display("FAIL rnd_maxwait p%0d got %0d want <=1", p, waits[p]); end
        end
      end
      pend_port = -1;
      if (win >= 0) begin
        prev = win;
        idx = int'(m[win].address) - 'h40;
        if (m[win].write) shadow[idx] = merge(shadow[idx], m[win].writedata, m[win].byteenable);
        else begin pend_port = win; pend_data = shadow[idx]; end
        act[win] = 0; waits[win] = 0;
      end
      next();
    end
    idle();
    @(negedge clk);
    checks++;
    if (p0_readdatavalid !== (pend_port == 0) || p1_readdatavalid !== (pend_port == 1)) begin
      errors++; $display("FAIL rnd_drain got %b%b want owner %0d", p1_readdatavalid, p0_readdatavalid, pend_port);
    end
    next();
  endtask

  task automatic test_reset_mid_read();
    p0_address = 9'h005; p0_read = 1;
    @(negedge clk);
    checks++; if (p0_waitrequest !== 1'b0) begin errors++; $display("FAIL mid_rd_wait got %b want 0", p0_waitrequest); end
    next();
    idle();
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({p0_readdatavalid, p1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL mid_rst_valid cycle %0d got %b want 00", c, {p0_readdatavalid, p1_readdatavalid}); end
      next();
    end
    reset_n = 1'b1;
    p0_address = 9'h005; p0_read = 1; p1_address = 9'h030; p1_read = 1;
    @(negedge clk);
    checks++; if ({p0_readdatavalid, p1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL mid_rel_valid got %b want 00", {p0_readdatavalid, p1_readdatavalid}); end
    checks++; if ({p1_waitrequest, p0_waitrequest} !== 2'b10) begin errors++; $display("FAIL mid_first_conflict got w1w0=%b%b want 10", p1_waitrequest, p0_waitrequest); end
    next();
    p0_read = 0;
    @(negedge clk);
    checks++; if (p1_waitrequest !== 1'b0) begin errors++; $display("FAIL mid_p1_grant got %b want 0", p1_waitrequest); end
    checks++; if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_p0_data got v=%b d=%h want 1 deadbeef", p0_readdatavalid, p0_readdata); end
    next();
    idle();
    @(negedge clk);
    checks++; if (p1_readdatavalid !== 1'b1 || p1_readdata !== 32'h11AA3344) begin errors++; $display("FAIL mid_p1_data got v=%b d=%h want 1 11aa3344", p1_readdatavalid, p1_readdata); end
    next();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_lock();
    test_byte_lane();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares one single-port on-chip RAM (512 x 32, byte-enabled, synchronous read, 1-cycle read latency) between two Avalon-MM masters, e.g. the Nios data master and a DMA/cartridge-emulation engine.
- Round-robin arbitration, one access per cycle, pipelined reads returned with readdatavalid.
- Optional per-port lock keeps the grant across an atomic read-modify-write.
- Sits between the interconnect and the RAM wrapper; drives the RAM address, byteenable, chipselect, write and clken pins directly.

Parameters:
- ADDR_W, 9, word address width (512 words).
- DATA_W, 32, data width; must be a multiple of 8.
- BE_W, DATA_W/8, byteenable width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins.

Ports:
- clk  in  1  single clock for all logic and the RAM.
- reset_n  in  1  asynchronous, active-low reset.
- p0_address  in  ADDR_W  port 0 word address.
- p0_byteenable  in  BE_W  port 0 byte lanes.
- p0_read  in  1  port 0 read request.
- p0_write  in  1  port 0 write request.
- p0_writedata  in  DATA_W  port 0 write data.
- p0_lock  in  1  port 0 holds grant while high.
- p0_waitrequest  out  1  port 0 request not accepted this cycle.
- p0_readdata  out  DATA_W  port 0 read data.
- p0_readdatavalid  out  1  port 0 read data valid.
- p1_*  (same set as p0_*)  port 1.
- ram_address  out  ADDR_W  RAM address.
- ram_byteenable  out  BE_W  RAM byte lanes.
- ram_chipselect  out  1  RAM select.
- ram_write  out  1  RAM write.
- ram_writedata  out  DATA_W  RAM write data.
- ram_clken  out  1  RAM clock enable; constant 1.
- ram_readdata  in  DATA_W  RAM q, valid the cycle after a read is accepted.

Behaviour:
- Request: px_req = px_read | px_write. Read and write asserted together on one port is illegal; treat it as a write. Flag it with an assertion in simulation.
- Grant is combinational on the current requests plus registered state. The granted port sees waitrequest=0 in the same cycle (acceptance cycle). A non-granted requester sees waitrequest=1 and must hold its signals stable.
- An idle port sees waitrequest=1 (Avalon-legal); the bench must not depend on this.
- RAM outputs carry the granted port's address, byteenable and writedata:
  - chipselect=1 on any accepted access.
  - ram_write=1 only for an accepted write.
  - With no grant: chipselect=0, write=0; address, byteenable and writedata hold the port 0 values.
- Arbitration, round-robin:
  - Register last_grant (reset to 1, so port 0 wins the first conflict).
  - Single requester is granted immediately.
  - On conflict, grant the port that is not last_grant.
  - last_grant updates on every accepted access.
  - Under continuous contention, grants alternate and no port waits more than 1 cycle.
  - FIXED_PRIO=1 ignores last_grant.
- Lock state machine:
  - States: UNLOCKED, LOCKED0, LOCKED1.
  - UNLOCKED -> LOCKEDx when port x is accepted with px_lock=1.
  - LOCKEDx grants only port x; the other port waits.
  - LOCKEDx -> UNLOCKED on the first cycle px_lock=0; the grant is re-evaluated in that same cycle.
  - Lock never overrides an access already accepted.
- Read return:
  - Registers rd_pending (reset 0) and rd_owner (reset 0) are loaded at an accepted read.
  - Next cycle: p{rd_owner}_readdatavalid = rd_pending.
  - Both ports' readdata = ram_readdata combinationally; only the owner's valid is asserted.
  - Latency is exactly 1 cycle; back-to-back reads give 1 result per cycle in order.
  - A write accepted in the cycle a read returns is legal; the RAM handles it independently.
- Reset values, while reset_n=0 and at the first edge after release:
  - readdatavalid = 0 on both ports.
  - waitrequest = 1 on both ports.
  - ram_chipselect = 0, ram_write = 0.
  - State = UNLOCKED, last_grant = 1.
- Reset asserted mid-read drops the pending readdatavalid. The master is reset alongside.
- Address wrap: none; addresses pass through unmodified.

Decomposition:
- Shared package onchip_mem_pkg holds:
  - constants for ADDR_W/DATA_W defaults;
  - a lock-state enum (UNLOCKED, LOCKED0, LOCKED1);
  - a port-request struct (address, byteenable, read, write, writedata, lock).
- One sub-module, rr_arb2: a 2-input round-robin/fixed-priority grant with last_grant register and lock override. It outputs a one-hot grant.
- Top level holds the muxing and the read-return pipeline.

Test Plan:
- Reset release, no requests -> both readdatavalid=0, ram_chipselect=0, ram_write=0 for 10 cycles.
- p0 writes 0xDEADBEEF to addr 0x005 with BE=0xF, then reads 0x005 -> p0_waitrequest=0 both cycles; p0_readdatavalid=1 exactly 1 cycle after the read with readdata=0xDEADBEEF; p1_readdatavalid stays 0.
- p0 and p1 read addr 0x010 and 0x011 continuously for 8 cycles (RAM preloaded 0x10/0x11) -> grants alternate p0,p1,p0,…; each port gets 4 valids with the correct data; max 1 wait cycle per request.
- p1 asserts lock with read 0x020 (value 0x5), p0 requests every cycle; p1 writes 0x6 with BE=0x1 then drops lock -> p0 waits for exactly 2 cycles, is granted the cycle lock drops, and a read of 0x020 returns 0x6.
- Byte-lane write BE=0x4 with data 0x00AA0000 over 0x11223344 -> readback 0x11AA3344.
- Assert reset_n low in the cycle after an accepted read -> no readdatavalid is seen; after release, the first conflict is won by p0.
